// File: rtl/des_round_controller.sv
// des_round_controller: sequences load, 16 Feistel rounds, output capture and done for one DES block
module des_round_controller (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       decrypt,
    output logic       ready,
    output logic       load_block,
    output logic       key_load,
    output logic       round_en,
    output logic [3:0] round_num,
    output logic [1:0] shift_amt,
    output logic       shift_right,
    output logic       out_load,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINISH, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       mode, mode_nxt;

    // State, round counter and latched mode registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mode  <= mode_nxt;
        end
    end

    // Next state; counter runs only inside ROUND and is cleared on leaving it, mode latched on accept
    always_comb begin
        state_nxt = state;
        cnt_nxt   = 4'd0;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                state_nxt = start ? LOAD : IDLE;
                mode_nxt  = start ? decrypt : mode;
            end
            LOAD:   state_nxt = ROUND;
            ROUND: begin
                state_nxt = (cnt == 4'd15) ? FINISH : ROUND;
                cnt_nxt   = (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
            end
            FINISH: state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs; decrypt skips the rotate before round 0 and rotates right thereafter
    always_comb begin
        ready       = state == IDLE;
        load_block  = state == LOAD;
        key_load    = state == LOAD;
        round_en    = state == ROUND;
        round_num   = (state == ROUND) ? cnt : 4'd0;
        shift_right = mode;
        out_load    = state == FINISH;
        done        = state == DONE;
        shift_amt   = (state != ROUND) ? 2'd0 :
                      (mode && cnt == 4'd0) ? 2'd0 :
                      (cnt == 4'd0 || cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15) ? 2'd1 : 2'd2;
    end

endmodule

// File: tb/tb_des_round_controller.sv
// tb_des_round_controller: directed and random checks of the DES round controller against a phase model
module tb_des_round_controller;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start = 1'b0;
    logic       decrypt = 1'b0;
    logic       ready, load_block, key_load, round_en, shift_right, out_load, done;
    logic [3:0] round_num;
    logic [1:0] shift_amt;

    int vecs = 0;
    int errs = 0;

    des_round_controller dut (
        .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt),
        .ready(ready), .load_block(load_block), .key_load(key_load),
        .round_en(round_en), .round_num(round_num), .shift_amt(shift_amt),
        .shift_right(shift_right), .out_load(out_load), .done(done)
    );

    always #5 clk = ~clk;

    // Model: t counts cycles since accept (0 idle, 1 load, 2..17 rounds, 18 finish, 19 done)
    int   t = 0;
    logic m = 1'b0;

    function automatic int model_amt(input int n, input logic d);
        if (d && n == 0) return 0;
        return (n inside {0, 1, 8, 15}) ? 1 : 2;
    endfunction

    // Advance the model on each clock; reset returns it to idle encrypt
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            t <= 0;
            m <= 1'b0;
        end else if (t == 0) begin
            if (start) begin
                t <= 1;
                m <= decrypt;
            end
        end else begin
            t <= (t == 19) ? 0 : t + 1;
        end
    end

    // Compare every output against the model each cycle, plus the structural invariants
    always @(negedge clk) begin
        logic       e_rnd;
        int         num;
        logic [12:0] act, exp;
        e_rnd = t >= 2 && t <= 17;
        num   = e_rnd ? t - 2 : 0;
        exp = {t == 0, t == 1, t == 1, e_rnd, 4'(num),
               2'(e_rnd ? model_amt(num, m) : 0), m, t == 18, t == 19};
        act = {ready, load_block, key_load, round_en, round_num, shift_amt, shift_right, out_load, done};
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL model t=%0d: got %b want %b", t, act, exp);
        end
        vecs++;
        assert ($onehot0({load_block, round_en, out_load, done}) && round_num <= 4'd15)
        else begin
            errs++;
            $display("FAIL invariant: strobes %b round_num %0d", {load_block, round_en, out_load, done}, round_num);
        end
    end

    int          cyc, ld_cnt, rnd_cnt, ol_cnt, done_cnt, ready_cnt, run, run_max, sr_cnt, ld_idx, done_idx;
    logic [31:0] amt_seq;

    task automatic clr();
        cyc = 0; ld_cnt = 0; rnd_cnt = 0; ol_cnt = 0; done_cnt = 0; ready_cnt = 0;
        run = 0; run_max = 0; sr_cnt = 0; ld_idx = -1; done_idx = -1; amt_seq = 0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (load_block) begin
                ld_cnt++;
                if (ld_idx < 0) ld_idx = cyc;
            end
            if (round_en) begin
                rnd_cnt++;
                amt_seq = {amt_seq[29:0], shift_amt};
                if (shift_right) sr_cnt++;
            end
            if (out_load) ol_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = cyc;
            end
            run = ready ? run + 1 : 0;
            if (ready) ready_cnt++;
            if (run > run_max) run_max = run;
            cyc++;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic go(input logic d);
        @(posedge clk); #1 start = 1'b1; decrypt = d;
        @(posedge clk); #1 start = 1'b0;
        clr();
    endtask

    initial begin
        n_rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_strobes", {load_block, key_load, round_en, out_load, done}, 0);
        chk("rst_num_amt_dir", {round_num, shift_amt, shift_right}, 0);
        #2 n_rst = 1'b1;

        go(1'b0);
        watch(22);
        chk("enc_load", ld_cnt, 1);
        chk("enc_rounds", rnd_cnt, 16);
        chk("enc_amts", amt_seq, 32'h5AAA6AA9);
        chk("enc_dir", sr_cnt, 0);
        chk("enc_outload", ol_cnt, 1);
        chk("enc_done", done_cnt, 1);
        chk("enc_latency", done_idx, 18);
        chk("enc_occupancy", done_idx - ld_idx + 1, 19);

        go(1'b1);
        watch(22);
        chk("dec_rounds", rnd_cnt, 16);
        chk("dec_amts", amt_seq, 32'h1AAA6AA9);
        chk("dec_dir", sr_cnt, 16);
        chk("dec_done", done_cnt, 1);
        chk("dec_latency", done_idx, 18);

        go(1'b0);
        watch(7);
        chk("busy_rn", round_num, 5);
        start = 1'b1; decrypt = 1'b1;
        watch(1);
        start = 1'b0;
        watch(24);
        decrypt = 1'b0;
        chk("busy_load", ld_cnt, 1);
        chk("busy_done", done_cnt, 1);
        chk("busy_amts", amt_seq, 32'h5AAA6AA9);
        chk("busy_dir", sr_cnt, 0);

        @(posedge clk); #1 start = 1'b1;
        clr();
        watch(60);
        start = 1'b0;
        chk("cont_done", done_cnt, 3);
        chk("cont_load", ld_cnt, 3);
        chk("cont_ready_total", ready_cnt, 3);
        chk("cont_ready_run", run_max, 1);
        watch(25);

        go(1'b1);
        watch(11);
        chk("abort_rn", round_num, 9);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_outs", {load_block, key_load, round_en, round_num, shift_amt, shift_right, out_load, done}, 0);
        @(negedge clk); #2 n_rst = 1'b1;
        clr();
        watch(25);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_load", ld_cnt, 0);
        go(1'b0);
        watch(22);
        chk("abort_fresh_done", done_cnt, 1);
        chk("abort_fresh_amts", amt_seq, 32'h5AAA6AA9);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start   = $urandom_range(0, 3) == 0;
            decrypt = $urandom_range(0, 1) == 1;
            n_rst   = $urandom_range(0, 99) != 0;
        end
        @(posedge clk); #1 n_rst = 1'b1; start = 1'b0;
        repeat (25) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
